// File: rtl/pixel_scan_addr.sv
// pixel_scan_addr
//   Raster-scan address generator. An accepted start latches the frame
//   geometry and then streams one beat per pixel, x fastest, through a
//   three-stage pipeline:
//     S1 scan counters, S2 row product y*stride, S3 output address sum.
//   The whole pipeline advances under a single enable, which is high
//   whenever S3 is empty or the consumer takes the current beat.
//
// Ports
//   ap_clk, ap_rst_n     clock and asynchronous active-low reset
//   start                frame request, sampled only while idle
//   width, height        frame size in pixels and lines
//   stride               address units per line
//   base_addr            frame base address
//   busy                 high while a frame is being scanned
//   done                 one-cycle pulse after the final beat, or after a
//                        start that requests an empty frame
//   m_valid, m_ready     output beat handshake
//   m_x, m_y             pixel coordinates of the beat
//   m_addr               base_addr + m_y*stride + m_x, wrapping at ADDR_W
//   m_user, m_last       first pixel of frame / last pixel of line
module pixel_scan_addr #(
  parameter int X_W      = 11,
  parameter int STRIDE_W = 13,
  parameter int ADDR_W   = 32
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      width,
  input  logic [X_W-1:0]      height,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [X_W-1:0]      m_x,
  output logic [X_W-1:0]      m_y,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_user,
  output logic                m_last
);

  localparam int PROD_W = X_W + STRIDE_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;
  logic   done_nxt;

  logic [X_W-1:0]      width_r, height_r;
  logic [STRIDE_W-1:0] stride_r;
  logic [ADDR_W-1:0]   base_r;

  logic [X_W-1:0] cx, cy;
  logic           gen_act;

  logic [X_W-1:0]    x_p0, y_p0, x_p1, y_p1, x_p2, y_p2;
  logic              vld_p0, vld_p1, vld_p2;
  logic              user_p0, user_p1, user_p2;
  logic              last_p0, last_p1, last_p2;
  logic              fin_p0, fin_p1, fin_p2;
  logic [PROD_W-1:0] prod_p1;
  logic [ADDR_W-1:0] addr_p2;

  logic en, accept, empty_req, final_hs, gen_xl, gen_yl;

  // Unsigned address sum; any carry past ADDR_W is discarded.
  function automatic logic [ADDR_W-1:0] addr_sum(input logic [ADDR_W-1:0] b,
                                                 input logic [PROD_W-1:0] p,
                                                 input logic [X_W-1:0]    x);
    return b + ADDR_W'(p) + ADDR_W'(x);
  endfunction

  assign en        = !vld_p2 || m_ready;
  assign accept    = (state == IDLE) && start && (width != '0) && (height != '0);
  assign empty_req = (state == IDLE) && start && ((width == '0) || (height == '0));
  assign final_hs  = vld_p2 && m_ready && fin_p2;
  assign gen_xl    = (cx == width_r - X_W'(1));
  assign gen_yl    = (cy == height_r - X_W'(1));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
        if (empty_req) done_nxt = 1'b1;
      end
      RUN: begin
        if (final_hs) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Operand latch and coordinate generator feeding S1.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      width_r  <= '0;
      height_r <= '0;
      stride_r <= '0;
      base_r   <= '0;
      cx       <= '0;
      cy       <= '0;
      gen_act  <= 1'b0;
    end else if (accept) begin
      width_r  <= width;
      height_r <= height;
      stride_r <= stride;
      base_r   <= base_addr;
      cx       <= '0;
      cy       <= '0;
      gen_act  <= 1'b1;
    end else if (en && gen_act) begin
      if (gen_xl) begin
        cx <= '0;
        if (gen_yl) gen_act <= 1'b0;
        else        cy      <= cy + X_W'(1);
      end else begin
        cx <= cx + X_W'(1);
      end
    end
  end

  // S1: scan counters
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p0  <= 1'b0;
      x_p0    <= '0;
      y_p0    <= '0;
      user_p0 <= 1'b0;
      last_p0 <= 1'b0;
      fin_p0  <= 1'b0;
    end else if (en) begin
      vld_p0  <= gen_act;
      x_p0    <= cx;
      y_p0    <= cy;
      user_p0 <= gen_act && (cx == '0) && (cy == '0);
      last_p0 <= gen_act && gen_xl;
      fin_p0  <= gen_act && gen_xl && gen_yl;
    end
  end

  // S2: full-width row product
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p1  <= 1'b0;
      x_p1    <= '0;
      y_p1    <= '0;
      prod_p1 <= '0;
      user_p1 <= 1'b0;
      last_p1 <= 1'b0;
      fin_p1  <= 1'b0;
    end else if (en) begin
      vld_p1  <= vld_p0;
      x_p1    <= x_p0;
      y_p1    <= y_p0;
      prod_p1 <= PROD_W'(y_p0) * PROD_W'(stride_r);
      user_p1 <= user_p0;
      last_p1 <= last_p0;
      fin_p1  <= fin_p0;
    end
  end

  // S3: output address
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p2  <= 1'b0;
      x_p2    <= '0;
      y_p2    <= '0;
      addr_p2 <= '0;
      user_p2 <= 1'b0;
      last_p2 <= 1'b0;
      fin_p2  <= 1'b0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      x_p2    <= x_p1;
      y_p2    <= y_p1;
      addr_p2 <= addr_sum(base_r, prod_p1, x_p1);
      user_p2 <= user_p1;
      last_p2 <= last_p1;
      fin_p2  <= fin_p1;
    end
  end

  assign busy    = (state == RUN);
  assign m_valid = vld_p2;
  assign m_x     = x_p2;
  assign m_y     = y_p2;
  assign m_addr  = addr_p2;
  assign m_user  = user_p2;
  assign m_last  = last_p2;

endmodule

// File: tb/tb_pixel_scan_addr.sv
module tb_pixel_scan_addr;
  localparam int X_W = 11, STRIDE_W = 13, ADDR_W = 32;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic                start = 1'b0;
  logic [X_W-1:0]      width = '0, height = '0;
  logic [STRIDE_W-1:0] stride = '0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic                m_ready = 1'b1;
  logic                busy, done, m_valid, m_user, m_last;
  logic [X_W-1:0]      m_x, m_y;
  logic [ADDR_W-1:0]   m_addr;

  pixel_scan_addr #(.X_W(X_W), .STRIDE_W(STRIDE_W), .ADDR_W(ADDR_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .width(width),
    .height(height), .stride(stride), .base_addr(base_addr), .busy(busy),
    .done(done), .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
    .m_addr(m_addr), .m_user(m_user), .m_last(m_last));

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [X_W-1:0]    x, y;
    logic [ADDR_W-1:0] addr;
    logic              user, last;
  } beat_t;

  beat_t             exp_q[$];
  logic [ADDR_W-1:0] got_q[$];
  int  checks = 0, errors = 0, cyc = 0, start_cyc = 0;
  bit  run = 0, exp_done = 0, prev_stall = 0, seen_first = 0, rnd_ready = 0;
  logic [X_W-1:0]    prev_x, prev_y;
  logic [ADDR_W-1:0] prev_addr;
  logic              prev_user, prev_last;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b,
      input logic [STRIDE_W-1:0] s, input logic [X_W-1:0] x, input logic [X_W-1:0] y);
    return b + 32'(y) * 32'(s) + 32'(x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model and compare process; inputs change only just after a
  // rising edge, so at the falling edge both sides are settled.
  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
      chk("rst_valid", m_valid, 0); chk("rst_addr", m_addr, 0);
      chk("rst_x", m_x, 0);         chk("rst_y", m_y, 0);
      chk("rst_user", m_user, 0);   chk("rst_last", m_last, 0);
      exp_q.delete();
      run = 0; exp_done = 0; prev_stall = 0;
    end else begin : live
      bit run_now;
      run_now = run;
      chk("done", done, exp_done);
      chk("busy", busy, run);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1); chk("stall_addr", m_addr, prev_addr);
        chk("stall_x", m_x, prev_x);    chk("stall_y", m_y, prev_y);
        chk("stall_user", m_user, prev_user); chk("stall_last", m_last, prev_last);
      end
      exp_done = 0;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", m_valid, 0);
        end else begin
          if (!seen_first) begin
            chk("first_latency", cyc - start_cyc, 4);
            seen_first = 1;
          end
          chk("beat_x", m_x, exp_q[0].x);       chk("beat_y", m_y, exp_q[0].y);
          chk("beat_addr", m_addr, exp_q[0].addr);
          chk("beat_user", m_user, exp_q[0].user);
          chk("beat_last", m_last, exp_q[0].last);
          if (m_ready) begin
            got_q.push_back(m_addr);
            exp_q.delete(0);
            if (exp_q.size() == 0) begin
              exp_done = 1;
              run = 0;
            end
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_x = m_x; prev_y = m_y; prev_addr = m_addr;
      prev_user = m_user; prev_last = m_last;
      if (!run_now && start) begin
        if (width != 0 && height != 0) begin
          for (int yy = 0; yy < int'(height); yy++)
            for (int xx = 0; xx < int'(width); xx++) begin
              beat_t b;
              b.x = X_W'(xx);
              b.y = X_W'(yy);
              b.addr = addr_of(base_addr, stride, X_W'(xx), X_W'(yy));
              b.user = (xx == 0) && (yy == 0);
              b.last = (xx == int'(width) - 1);
              exp_q.push_back(b);
            end
          run = 1; seen_first = 0; start_cyc = cyc;
        end else begin
          exp_done = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge ap_clk); #1;
      m_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic start_frame(input int w, input int h, input int s, input logic [ADDR_W-1:0] b);
    @(posedge ap_clk); #1;
    width = X_W'(w); height = X_W'(h); stride = STRIDE_W'(s); base_addr = b;
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    width = X_W'(7); height = X_W'(9); stride = STRIDE_W'(3); base_addr = 32'hDEAD0000;
  endtask

  task automatic wait_frame(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge ap_clk);
      if (!run && exp_q.size() == 0) break;
    end
    chk("frame_timeout", run, 0);
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    bit found;
    #1;
    chk("init_busy", busy, 0); chk("init_valid", m_valid, 0); chk("init_done", done, 0);
    chk("model_pin_corner", addr_of(32'hFFFFFFF0, 13'd8191, 11'd2046, 11'd2046), 32'h00FFBFF0);
    chk("model_pin_small", addr_of(32'h1000, 13'd8, 11'd3, 11'd1), 32'h100B);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    // 4x2 frame, ready held high
    got_q.delete();
    start_frame(4, 2, 8, 32'h1000);
    wait_frame(100);
    chk("f1_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      chk("f1_b0", got_q[0], 32'h1000); chk("f1_b3", got_q[3], 32'h1003);
      chk("f1_b4", got_q[4], 32'h1008); chk("f1_b7", got_q[7], 32'h100B);
    end

    // same frame with random backpressure
    rnd_ready = 1;
    got_q.delete();
    start_frame(4, 2, 8, 32'h1000);
    wait_frame(400);
    rnd_ready = 0;
    chk("f2_count", got_q.size(), 8);
    if (got_q.size() == 8) chk("f2_b7", got_q[7], 32'h100B);

    // empty frame: done only
    start_frame(0, 5, 8, 32'h2000);
    repeat (4) @(posedge ap_clk);

    // single-column and single-pixel frames
    start_frame(1, 3, 16, 32'h40);
    wait_frame(100);
    start_frame(1, 1, 5, 32'h80);
    wait_frame(100);

    // start while busy is ignored
    got_q.delete();
    start_frame(3, 2, 4, 32'h500);
    start_frame(6, 6, 1, 32'h900);
    wait_frame(200);
    chk("busy_start_count", got_q.size(), 6);

    // new start in the done cycle
    start_frame(2, 2, 4, 32'h600);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge ap_clk); #1;
      if (done) begin found = 1; break; end
    end
    chk("done_seen", found, 1);
    width = 11'd3; height = 11'd1; stride = 13'd0; base_addr = 32'hA00;
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    wait_frame(100);

    // wide frame with address wrap, random backpressure
    rnd_ready = 1;
    got_q.delete();
    start_frame(2047, 2, 8191, 32'hFFFFFFF0);
    wait_frame(20000);
    rnd_ready = 0;
    chk("wrap_count", got_q.size(), 4094);
    if (got_q.size() == 4094) begin
      chk("wrap_row1_first", got_q[2047], 32'h00001FEF);
      chk("wrap_final", got_q[4093], 32'h000027ED);
    end

    // reset mid-frame, then a fresh frame
    start_frame(5, 4, 10, 32'h3000);
    repeat (6) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", busy, 0);   chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_addr", m_addr, 0); chk("mid_rst_x", m_x, 0);
    chk("mid_rst_user", m_user, 0); chk("mid_rst_done", done, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    got_q.delete();
    start_frame(3, 1, 0, 32'h7000);
    wait_frame(100);
    chk("post_rst_count", got_q.size(), 3);
    if (got_q.size() == 3) chk("post_rst_b0", got_q[0], 32'h7000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
